// File: rtl/prim_word_packer_if.sv
// rtl/prim_word_packer_if.sv - entry-in / packed-word-out handshake bundle for prim_word_packer
interface prim_word_packer_if #(
   parameter int InW   = 16,
   parameter int Ratio = 4
);
   localparam int OutW = InW * Ratio;
   localparam int CntW = (Ratio > 1) ? $clog2(Ratio) : 1;

   logic            clr_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [InW-1:0]  in_data_i;
   logic            flush_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [OutW-1:0] out_data_o;
   logic [Ratio-1:0] out_mask_o;
   logic [CntW-1:0] lanes_o;

   // Packer side
   modport slave (
      input  clr_i, in_valid_i, in_data_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_mask_o, lanes_o
   );

   // Upstream FIFO / wide consumer side
   modport master (
      output clr_i, in_valid_i, in_data_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_mask_o, lanes_o
   );
endinterface

// File: rtl/prim_word_packer.sv
// rtl/prim_word_packer.sv - packs Ratio narrow entries into one wide word; flush gated by PRIM_WORD_PACKER_FLUSH_EN
module prim_word_packer #(
   parameter int InW   = 16,
   parameter int Ratio = 4
) (
   input logic               clk_i,
   input logic               rst_ni,
   prim_word_packer_if.slave bus
);
   localparam int OutW = InW * Ratio;
   localparam int CntW = (Ratio > 1) ? $clog2(Ratio) : 1;
   localparam logic [CntW-1:0] LastLane = CntW'(Ratio - 1);

   // Lanes 0..Ratio-2 are buffered; the last lane goes straight into the output word
   logic [Ratio-2:0][InW-1:0] acc_q;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [OutW-1:0]           out_q, load_data;
   logic                      out_valid_q, out_valid_d;
   logic                      out_valid;
   logic                      under_rst;
   logic                      slot_free, accept, load, acc_we;
   logic                      flush_block;

`ifdef PRIM_WORD_PACKER_FLUSH_EN
   logic [Ratio-1:0] mask_q, load_mask;
   logic             flush_pend_q, flush_pend_d;
   logic             flush_eff;

   assign flush_eff   = bus.flush_i | flush_pend_q;
   assign flush_block = flush_pend_q;
`else
   logic unused_flush;

   assign unused_flush = bus.flush_i;
   assign flush_block  = 1'b0;
`endif

   assign slot_free      = ~out_valid_q | bus.out_ready_i;
   assign bus.in_ready_o = ~under_rst & ~flush_block & ((cnt_q != LastLane) | slot_free);
   assign accept         = bus.in_valid_i & bus.in_ready_o;

   // Decide accumulator write, word load (full or partial) and next counter/pending state
   always_comb begin
      load      = 1'b0;
      acc_we    = 1'b0;
      load_data = '0;
      cnt_d     = cnt_q;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
      load_mask    = '0;
      flush_pend_d = flush_pend_q;
`endif
      if (accept) begin
         if (cnt_q == LastLane) begin
            load      = 1'b1;
            load_data = {bus.in_data_i, acc_q};
            cnt_d     = '0;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
            load_mask = '1;
`endif
         end else begin
            acc_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
         end
      end
`ifdef PRIM_WORD_PACKER_FLUSH_EN
      // cnt_d is the lane count including a same-cycle accept; zero means nothing to flush
      if (flush_eff && !load && (cnt_d != '0)) begin
         if (slot_free) begin
            load = 1'b1;
            for (int k = 0; k < Ratio - 1; k++) begin
               if (CntW'(k) < cnt_q) begin
                  load_data[k*InW +: InW] = acc_q[k];
               end else if (accept && (CntW'(k) == cnt_q)) begin
                  load_data[k*InW +: InW] = bus.in_data_i;
               end
            end
            for (int k = 0; k < Ratio; k++) begin
               load_mask[k] = (CntW'(k) < cnt_d);
            end
            cnt_d        = '0;
            flush_pend_d = 1'b0;
         end else begin
            flush_pend_d = 1'b1;
         end
      end
`endif
      if (load) begin
         out_valid_d = 1'b1;
      end else if (bus.out_ready_i) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Hold off the input handshake for the first edge after reset release
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         under_rst <= 1'b1;
      end else begin
         under_rst <= 1'b0;
      end
   end

   // Control state; clear wins over accept and flush
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
         flush_pend_q <= 1'b0;
`endif
      end else if (bus.clr_i) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
         flush_pend_q <= 1'b0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
         flush_pend_q <= flush_pend_d;
`endif
      end
   end

   // Accumulator lanes and output word; clear leaves the data untouched
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         out_q <= '0;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
         mask_q <= '0;
`endif
      end else if (!bus.clr_i) begin
         for (int k = 0; k < Ratio - 1; k++) begin
            if (acc_we && (cnt_q == CntW'(k))) begin
               acc_q[k] <= bus.in_data_i;
            end
         end
         if (load) begin
            out_q <= load_data;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
            mask_q <= load_mask;
`endif
         end
      end
   end

   assign out_valid       = out_valid_q & ~under_rst;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_valid ? out_q : '0;
`ifdef PRIM_WORD_PACKER_FLUSH_EN
   assign bus.out_mask_o  = out_valid ? mask_q : '0;
`else
   assign bus.out_mask_o  = {Ratio{out_valid}};
`endif
   assign bus.lanes_o     = cnt_q;

endmodule

// File: tb/tb_prim_word_packer.sv
// tb/tb_prim_word_packer.sv - directed self-checking bench for prim_word_packer
module tb_prim_word_packer;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   prim_word_packer_if #(.InW(16), .Ratio(4)) bus ();

   prim_word_packer #(.InW(16), .Ratio(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input logic [15:0] d);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = d;
      mid();
      chk("push_in_ready", 64'(bus.in_ready_o), 64'd1);
      cyc();
      bus.in_valid_i = 1'b0;
   endtask

   initial begin
      bus.clr_i       = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.flush_i     = 1'b0;
      bus.out_ready_i = 1'b1;

      // Reset state
      cyc();
      mid();
      chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("rst_out_data", bus.out_data_o, 64'd0);
      chk("rst_out_mask", 64'(bus.out_mask_o), 64'd0);
      chk("rst_lanes", 64'(bus.lanes_o), 64'd0);
      cyc();
      rst_n = 1'b1;
      mid();
      chk("first_cycle_in_ready", 64'(bus.in_ready_o), 64'd0);
      cyc();
      mid();
      chk("post_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
      cyc();

      // Full word
      push(16'h1111);
      push(16'h2222);
      push(16'h3333);
      mid();
      chk("full_lanes3", 64'(bus.lanes_o), 64'd3);
      cyc();
      push(16'h4444);
      mid();
      chk("full_valid", 64'(bus.out_valid_o), 64'd1);
      chk("full_data", bus.out_data_o, 64'h4444_3333_2222_1111);
      chk("full_mask", 64'(bus.out_mask_o), 64'hF);
      chk("full_lanes0", 64'(bus.lanes_o), 64'd0);
      cyc();
      mid();
      chk("drained_valid", 64'(bus.out_valid_o), 64'd0);
      chk("drained_data_zero", bus.out_data_o, 64'd0);
      cyc();

      // Backpressure: 8 entries with the consumer stalled
      bus.out_ready_i = 1'b0;
      for (int i = 1; i <= 7; i++) push(16'hB000 + 16'(i));
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 16'hB008;
      mid();
      chk("bp_in_ready_low", 64'(bus.in_ready_o), 64'd0);
      chk("bp_lanes3", 64'(bus.lanes_o), 64'd3);
      chk("bp_word1_held", bus.out_data_o, 64'hB004_B003_B002_B001);
      cyc();
      mid();
      chk("bp_still_low", 64'(bus.in_ready_o), 64'd0);
      chk("bp_still_valid", 64'(bus.out_valid_o), 64'd1);
      cyc();
      bus.out_ready_i = 1'b1;
      mid();
      chk("bp_ready_rises", 64'(bus.in_ready_o), 64'd1);
      cyc();
      bus.in_valid_i = 1'b0;
      mid();
      chk("bp_word2_valid", 64'(bus.out_valid_o), 64'd1);
      chk("bp_word2_data", bus.out_data_o, 64'hB008_B007_B006_B005);
      cyc();
      mid();
      chk("bp_word2_drained", 64'(bus.out_valid_o), 64'd0);
      cyc();

      // Clear with 3 lanes held
      push(16'hC001);
      push(16'hC002);
      push(16'hC003);
      bus.clr_i = 1'b1;
      cyc();
      bus.clr_i = 1'b0;
      mid();
      chk("clr_lanes", 64'(bus.lanes_o), 64'd0);
      chk("clr_out_valid", 64'(bus.out_valid_o), 64'd0);
      cyc();
      for (int i = 1; i <= 4; i++) push(16'hD000 + 16'(i));
      mid();
      chk("clr_next_word", bus.out_data_o, 64'hD004_D003_D002_D001);
      cyc();

      // Clear drops a held output word
      bus.out_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) push(16'hE000 + 16'(i));
      mid();
      chk("clr2_held_valid", 64'(bus.out_valid_o), 64'd1);
      cyc();
      bus.clr_i = 1'b1;
      cyc();
      bus.clr_i = 1'b0;
      mid();
      chk("clr2_valid_cleared", 64'(bus.out_valid_o), 64'd0);
      chk("clr2_data_zero", bus.out_data_o, 64'd0);
      cyc();
      bus.out_ready_i = 1'b1;

      // Reset after 2 accepted entries
      push(16'hF001);
      push(16'hF002);
      mid();
      chk("mid_rst_lanes2", 64'(bus.lanes_o), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_lanes", 64'(bus.lanes_o), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("mid_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      mid();
      chk("mid_rst_release_ready", 64'(bus.in_ready_o), 64'd0);
      cyc();
      for (int i = 1; i <= 4; i++) push(16'h5000 + 16'(i));
      mid();
      chk("mid_rst_clean_word", bus.out_data_o, 64'h5004_5003_5002_5001);
      chk("mid_rst_clean_mask", 64'(bus.out_mask_o), 64'hF);
      cyc();

`ifdef PRIM_WORD_PACKER_FLUSH_EN
      // Flush of two lanes with the slot free
      push(16'hAAAA);
      push(16'hBBBB);
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      mid();
      chk("flush_valid", 64'(bus.out_valid_o), 64'd1);
      chk("flush_data", bus.out_data_o, 64'h0000_0000_BBBB_AAAA);
      chk("flush_mask", 64'(bus.out_mask_o), 64'h3);
      chk("flush_lanes", 64'(bus.lanes_o), 64'd0);
      cyc();

      // Entry accepted alongside flush joins the partial word
      bus.flush_i = 1'b1;
      push(16'hCCCC);
      bus.flush_i = 1'b0;
      mid();
      chk("flush_acc_data", bus.out_data_o, 64'h0000_0000_0000_CCCC);
      chk("flush_acc_mask", 64'(bus.out_mask_o), 64'h1);
      cyc();

      // Flush with nothing held is a no-op
      mid();
      bus.flush_i = 1'b0;
      cyc();
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      mid();
      chk("flush_empty_valid", 64'(bus.out_valid_o), 64'd0);
      chk("flush_empty_ready", 64'(bus.in_ready_o), 64'd1);
      cyc();

      // Flush while the output is held
      bus.out_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) push(16'h9000 + 16'(i));
      push(16'h9005);
      push(16'h9006);
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      mid();
      chk("busy_in_ready_low", 64'(bus.in_ready_o), 64'd0);
      chk("busy_word_held", bus.out_data_o, 64'h9004_9003_9002_9001);
      cyc();
      bus.out_ready_i = 1'b1;
      mid();
      chk("busy_pend_ready_low", 64'(bus.in_ready_o), 64'd0);
      cyc();
      mid();
      chk("busy_partial_valid", 64'(bus.out_valid_o), 64'd1);
      chk("busy_partial_data", bus.out_data_o, 64'h0000_0000_9006_9005);
      chk("busy_partial_mask", 64'(bus.out_mask_o), 64'h3);
      chk("busy_ready_back", 64'(bus.in_ready_o), 64'd1);
      cyc();
`else
      // Flush is ignored in this build
      push(16'h7001);
      push(16'h7002);
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      mid();
      chk("noflush_valid", 64'(bus.out_valid_o), 64'd0);
      chk("noflush_lanes", 64'(bus.lanes_o), 64'd2);
      cyc();
      push(16'h7003);
      push(16'h7004);
      mid();
      chk("noflush_word", bus.out_data_o, 64'h7004_7003_7002_7001);
      chk("noflush_mask", 64'(bus.out_mask_o), 64'hF);
      cyc();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
